// File: rtl/comparator_persist.sv
// comparator_persist: registered six-mode magnitude comparator with run-length persistence detect (COMPARATOR_PERSIST_SIGNED_EN selects signed LT/GT/LE/GE)
module comparator_persist #(
    parameter int DATA_WIDTH = 13,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    input  logic [2:0]            mode_i,
    input  logic [CNT_WIDTH-1:0]  persist_i,
    input  logic                  clear_i,
    output logic                  valid_o,
    output logic                  cmp_o,
    output logic [CNT_WIDTH-1:0]  run_cnt_o,
    output logic                  hold_o,
    output logic                  hit_o
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
    state_t                 state;
    logic                   eq, lt, r;
    logic [CNT_WIDTH-1:0]   thr, cnt_nxt;
    // compare result, effective threshold and saturating next count
    always_comb begin
        eq = A_i == B_i;
`ifdef COMPARATOR_PERSIST_SIGNED_EN
        lt = $signed(A_i) < $signed(B_i);
`else
        lt = A_i < B_i;
`endif
        r = mode_i == 3'd0 ? eq :
            mode_i == 3'd1 ? !eq :
            mode_i == 3'd2 ? lt :
            mode_i == 3'd3 ? !lt && !eq :
            mode_i == 3'd4 ? lt || eq :
            mode_i == 3'd5 ? !lt : 1'b0;
        thr = persist_i == '0 ? CNT_WIDTH'(1) : persist_i;
        cnt_nxt = !r ? '0 : &run_cnt_o ? run_cnt_o : run_cnt_o + 1'b1;
    end
    // output registers, run counter and persistence state machine
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            cmp_o     <= 1'b0;
            run_cnt_o <= '0;
            hit_o     <= 1'b0;
            state     <= IDLE;
        end else begin
            valid_o <= valid_i;
            hit_o   <= 1'b0;
            if (valid_i) cmp_o <= r;
            if (clear_i) begin
                run_cnt_o <= '0;
                state     <= IDLE;
            end else if (valid_i) begin
                run_cnt_o <= cnt_nxt;
                if (!r) state <= IDLE;
                else if (cnt_nxt < thr) state <= COUNT;
                else begin
                    state <= HOLD;
                    hit_o <= state != HOLD;
                end
            end
        end
    end
    assign hold_o = state == HOLD;
endmodule

// File: tb/tb_comparator_persist.sv
// tb_comparator_persist: directed and randomized checks of comparator_persist against a run-length reference model
module tb_comparator_persist;
    localparam int DW  = 13;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;
    logic          clk_i = 0;
    logic          rst_i = 0;
    logic          valid_i = 0;
    logic [DW-1:0] A_i = '0;
    logic [DW-1:0] B_i = '0;
    logic [2:0]    mode_i = '0;
    logic [CW-1:0] persist_i = '0;
    logic          clear_i = 0;
    logic          valid_o, cmp_o, hold_o, hit_o;
    logic [CW-1:0] run_cnt_o;
    int checks = 0;
    int failures = 0;
    int m_cnt = 0;
    bit m_valid = 0, m_cmp = 0, m_hold = 0, m_hit = 0;

    comparator_persist #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .A_i(A_i), .B_i(B_i),
        .mode_i(mode_i), .persist_i(persist_i), .clear_i(clear_i),
        .valid_o(valid_o), .cmp_o(cmp_o), .run_cnt_o(run_cnt_o),
        .hold_o(hold_o), .hit_o(hit_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int to_num(int x);
`ifdef COMPARATOR_PERSIST_SIGNED_EN
        return x >= (1 << (DW - 1)) ? x - (1 << DW) : x;
`else
        return x;
`endif
    endfunction

    function automatic bit ref_cmp(int md, int a, int b);
        int sa = to_num(a);
        int sb = to_num(b);
        case (md)
            0: return a == b;
            1: return a != b;
            2: return sa < sb;
            3: return sa > sb;
            4: return sa <= sb;
            5: return sa >= sb;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_o", int'(valid_o), int'(m_valid));
        chk("cmp_o", int'(cmp_o), int'(m_cmp));
        chk("run_cnt_o", int'(run_cnt_o), m_cnt);
        chk("hold_o", int'(hold_o), int'(m_hold));
        chk("hit_o", int'(hit_o), int'(m_hit));
    endtask

    task automatic do_reset();
        rst_i = 1;
        valid_i = $urandom_range(0, 1);
        clear_i = $urandom_range(0, 1);
        @(posedge clk_i);
        m_valid = 0; m_cmp = 0; m_cnt = 0; m_hold = 0; m_hit = 0;
        #1 check_all();
        rst_i = 0;
    endtask

    task automatic step(bit v, int a, int b, int md, int p, bit clr);
        bit r, nh;
        int thr;
        valid_i = v; A_i = DW'(a); B_i = DW'(b); mode_i = 3'(md);
        persist_i = CW'(p); clear_i = clr;
        @(posedge clk_i);
        r = ref_cmp(md, a, b);
        thr = p == 0 ? 1 : p;
        m_valid = v;
        if (v) m_cmp = r;
        m_hit = 0;
        if (clr) begin
            m_cnt = 0;
            m_hold = 0;
        end else if (v) begin
            m_cnt = r ? (m_cnt + 1 > MAX ? MAX : m_cnt + 1) : 0;
            nh = r && m_cnt >= thr;
            m_hit = nh && !m_hold;
            m_hold = nh;
        end
        #1 check_all();
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        do_reset();
        step(1, 'h0A5, 'h0A5, 0, 1, 0);
        step(1, 'h0A5, 'h0A4, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 'h010, 'h00F, 5, 3, 0);
            step(0, 'h000, 'h0FF, 5, 3, 0);
            step(0, 'h000, 'h0FF, 5, 3, 0);
        end
        step(1, 'h001, 'h002, 5, 3, 0);
        step(1, 'h001, 'h002, 5, 0, 0);
        step(1, 'h002, 'h002, 5, 0, 0);
        step(1, 'h1FFF, 'h0001, 2, 1, 0);
        step(1, 'h0001, 'h1FFF, 3, 1, 0);
        step(1, 'h1FFF, 'h1FFF, 4, 1, 0);
        step(1, 'h1000, 'h0FFF, 5, 1, 0);
        step(1, 'h0005, 'h0005, 6, 1, 0);
        step(1, 'h0005, 'h0005, 7, 1, 0);
        step(1, 'h0003, 'h0004, 1, 2, 0);
        step(1, 'h0003, 'h0004, 1, 2, 0);
        step(1, 'h0003, 'h0004, 1, 2, 1);
        step(1, 'h0003, 'h0004, 1, 2, 0);
        step(1, 'h0003, 'h0004, 1, 2, 0);
        do_reset();
        for (int i = 0; i < MAX + 6; i++) step(1, 'h0AA, 'h0AA, 0, 2, 0);
        step(0, 'h000, 'h001, 0, 200, 0);
        step(1, 'h000, 'h001, 0, 2, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else step($urandom_range(0, 3) != 0,
                      $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, (1 << DW) - 1),
                      $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, (1 << DW) - 1),
                      $urandom_range(0, 7), $urandom_range(0, 5),
                      $urandom_range(0, 99) < 4);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparator_persist.md
Name: comparator_persist

Overview:
Parametrised, registered multi-mode magnitude comparator with persistence detection.
- Compares A_i against B_i in one of six selectable modes on each valid sample.
- Registers the result.
- Tracks how many consecutive valid samples produced a true result.
- Flags when that run reaches a programmable threshold.
- Sits in datapath monitoring and threshold-detect logic where a single-sample compare is too noise-sensitive.

Parameters:
DATA_WIDTH, 13, width of compared operands
CNT_WIDTH, 8, width of run counter and persistence threshold

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
valid_i  input  1  A_i/B_i/mode_i qualify a sample this cycle
A_i  input  DATA_WIDTH  operand A
B_i  input  DATA_WIDTH  operand B
mode_i  input  3  compare mode: 0 EQ, 1 NE, 2 LT, 3 GT, 4 LE, 5 GE, 6/7 reserved
persist_i  input  CNT_WIDTH  consecutive true samples required for hold_o; 0 treated as 1
clear_i  input  1  synchronous clear of run counter and state machine
valid_o  output  1  registered valid_i
cmp_o  output  1  registered compare result (A op B)
run_cnt_o  output  CNT_WIDTH  current consecutive-true count
hold_o  output  1  high while run count >= effective threshold
hit_o  output  1  single-cycle pulse on rising edge of hold_o

Behaviour:
- Reset (rst_i=1 at clock edge): valid_o=0, cmp_o=0, run_cnt_o=0, hold_o=0, hit_o=0, state=IDLE. Reset overrides clear_i and valid_i. Mid-run reset discards all progress.
- Combinational result r = (A_i op B_i) per mode_i. Reserved modes give r=0.
- Latency 1 cycle: valid_o <= valid_i every cycle. cmp_o <= r when valid_i=1, else holds its value.
- Effective threshold thr = (persist_i==0) ? 1 : persist_i. thr is sampled live each cycle.
- Counter update, on valid sample only:
  - r=1: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1.
  - r=0: cnt <= 0.
  - No valid sample: cnt and state hold. Gaps in valid_i do not break a run.
- State machine (hold_o = state==HOLD). On valid sample, next state is evaluated from the new count:
  - r=0 -> IDLE.
  - r=1 and new cnt < thr -> COUNT.
  - r=1 and new cnt >= thr -> HOLD.
  - A persist_i change takes effect at the next valid sample, not before.
- hit_o=1 for exactly the one cycle in which the state enters HOLD from IDLE or COUNT; 0 otherwise. Staying in HOLD gives no further pulses.
- clear_i=1 (rst_i=0): cnt <= 0, state <= IDLE, hit_o <= 0. clear_i takes priority over a simultaneous valid sample for counter and state only. valid_o and cmp_o still update from that sample.
- run_cnt_o, hold_o and hit_o all change on the same edge as the cmp_o of the sample that caused them.
- Without the optional feature, all magnitude modes are unsigned.

Optional Feature:
COMPARATOR_PERSIST_SIGNED_EN
- Defined: LT/GT/LE/GE treat A_i and B_i as two's-complement signed.
- Undefined: LT/GT/LE/GE are unsigned.
- EQ/NE are identical in both builds.

Test Plan:
1. EQ mode, A=B=0x0A5, valid_i=1 -> next cycle valid_o=1, cmp_o=1, run_cnt_o=1. Then A=0x0A5, B=0x0A4 -> cmp_o=0, run_cnt_o=0.
2. GE mode, persist_i=3, three valid samples with A=0x010, B=0x00F, idle cycles between them -> run_cnt_o 1,2,3. hold_o and hit_o rise with the 3rd result; hit_o low next cycle. 4th true sample -> hold_o stays 1, hit_o=0, run_cnt_o=4.
3. From HOLD, one valid false sample -> run_cnt_o=0, hold_o=0, state IDLE. persist_i=0 with one true sample -> hold_o=1 and hit_o=1 on that result.
4. LT mode, DATA_WIDTH=13, A=0x1FFF, B=0x0001 -> cmp_o=1 with COMPARATOR_PERSIST_SIGNED_EN defined, cmp_o=0 without.
5. CNT_WIDTH=2, persist_i=2, six consecutive true samples -> run_cnt_o 1,2,3,3,3,3. hold_o=1 from the 2nd result; single hit_o pulse.
6. clear_i=1 with a true valid sample while run_cnt_o=2 -> cmp_o=1, valid_o=1, run_cnt_o=0, hold_o=0. rst_i asserted mid-run in HOLD -> next cycle all outputs 0.
